l1_miss_handler: RTL and testbench

- Request-side controller placed directly upstream of the L1 cache. It accepts single-word CPU loads and stores, probes the cache, and on a load miss fetches the full 16-word block from main memory. It then installs that block in the cache with replacement enabled.
- Stores are write-through and no-write-allocate. The word goes to memory first, then updates the cache line only if the line is already present.

---
 rtl/cache_pkg.sv | 20 ++
 rtl/l1_miss_handler_if.sv | 47 ++++
 rtl/block_fill_buffer.sv | 23 ++
 rtl/l1_miss_handler.sv | 128 ++++++++++++
 tb/tb_l1_miss_handler.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// Shared L1 geometry, miss-handler state encoding and the single-word mask.
package cache_pkg;
    localparam int ADDRESSIZE    = 32;
    localparam int WORDSIZE      = 32;
    localparam int BLOCK_OFFSET  = 4;
    localparam int NUM_OF_BLOCKS = 2**BLOCK_OFFSET;
    localparam int BLOCKSIZE     = NUM_OF_BLOCKS*WORDSIZE;
    localparam int OFFSETSIZE    = 2;
    // word index sits at [IDX_LSB +: BLOCK_OFFSET], block tag above TAG_LSB
    localparam int IDX_LSB       = OFFSETSIZE;
    localparam int TAG_LSB       = OFFSETSIZE + BLOCK_OFFSET;

    localparam logic [BLOCKSIZE-1:0] WORD_MASK =
        {{(BLOCKSIZE-WORDSIZE){1'b0}}, {WORDSIZE{1'b1}}};

    typedef enum logic [2:0] {
        ST_IDLE, ST_LOOKUP, ST_CHECK, ST_FILL,
        ST_REFILL, ST_STORE_MEM, ST_STORE_CACHE, ST_DONE
    } mh_state_e;
endpackage

// File: rtl/l1_miss_handler_if.sv
// CPU, cache and memory signals of the miss handler in one bundle.
interface l1_miss_handler_if;
    import cache_pkg::*;

    logic                  cpu_req, cpu_we;
    logic [ADDRESSIZE-1:0] cpu_addr;
    logic [WORDSIZE-1:0]   cpu_wdata;
    logic                  cpu_busy, cpu_done;
    logic [WORDSIZE-1:0]   cpu_rdata;

    logic                  cache_r_en, cache_wr_en, cache_check_exist;
    logic [ADDRESSIZE-1:0] cache_address_read, cache_address_write;
    logic [BLOCKSIZE-1:0]  cache_data_in, cache_data_mask;
    logic                  cache_data_ready, cache_write_done;
    logic [WORDSIZE-1:0]   cache_data_out;

    logic                  mem_req, mem_we;
    logic [ADDRESSIZE-1:0] mem_addr;
    logic [WORDSIZE-1:0]   mem_wdata;
    logic                  mem_ack;
    logic [WORDSIZE-1:0]   mem_rdata;

    logic [15:0]           hit_cnt, miss_cnt;

    // master: the miss handler
    modport master (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_busy, cpu_done, cpu_rdata,
        output cache_r_en, cache_wr_en, cache_check_exist,
        output cache_address_read, cache_address_write, cache_data_in, cache_data_mask,
        input  cache_data_ready, cache_write_done, cache_data_out,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata,
        output hit_cnt, miss_cnt
    );

    modport slave (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_busy, cpu_done, cpu_rdata,
        input  cache_r_en, cache_wr_en, cache_check_exist,
        input  cache_address_read, cache_address_write, cache_data_in, cache_data_mask,
        output cache_data_ready, cache_write_done, cache_data_out,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata,
        input  hit_cnt, miss_cnt
    );
endinterface

// File: rtl/block_fill_buffer.sv
// Assembles a cache block one word at a time during a miss fill.
module block_fill_buffer
    import cache_pkg::*;
(
    input  logic                    clk,
    input  logic                    clear_i,
    input  logic                    we_i,
    input  logic [BLOCK_OFFSET-1:0] idx_i,
    input  logic [WORDSIZE-1:0]     data_i,
    output logic [BLOCKSIZE-1:0]    block_o,
    output logic [WORDSIZE-1:0]     word_o
);
    logic [NUM_OF_BLOCKS-1:0][WORDSIZE-1:0] buf_q;

    // clear wins so an abandoned fill never leaves stale words behind
    always_ff @(posedge clk) begin
        if (clear_i)   buf_q <= '0;
        else if (we_i) buf_q[idx_i] <= data_i;
    end

    assign block_o = buf_q;
    assign word_o  = buf_q[idx_i];
endmodule

// File: rtl/l1_miss_handler.sv
// Load/store front end for the L1: probe, fill on load miss, write-through stores.
module l1_miss_handler
    import cache_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    l1_miss_handler_if.master bus
);
    mh_state_e               state_q, state_d;
    logic [ADDRESSIZE-1:0]   addr_q;
    logic                    we_q;
    logic [WORDSIZE-1:0]     wdata_q, rdata_q, rdata_d;
    logic [BLOCK_OFFSET-1:0] idx_q, idx_d;
    logic [15:0]             hit_cnt_q, miss_cnt_q;

    logic                    accept, fill_wr;
    logic [BLOCK_OFFSET-1:0] word_sel, buf_idx;
    logic [BLOCKSIZE-1:0]    fill_block, store_mask, store_data;
    logic [WORDSIZE-1:0]     buf_word;

    assign word_sel = addr_q[IDX_LSB +: BLOCK_OFFSET];
    assign accept   = (state_q == ST_IDLE) && bus.cpu_req;
    assign fill_wr  = (state_q == ST_FILL) && bus.mem_ack;
    // buffer index is the fill pointer while filling, else the requested word
    assign buf_idx  = (state_q == ST_FILL) ? idx_q : word_sel;

    block_fill_buffer u_fill (
        .clk     (clk),
        .clear_i (~reset),
        .we_i    (fill_wr),
        .idx_i   (buf_idx),
        .data_i  (bus.mem_rdata),
        .block_o (fill_block),
        .word_o  (buf_word)
    );

    // state, request latch, fill index and saturating load counters
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            idx_q      <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rdata_q <= rdata_d;
            if (accept) begin
                addr_q  <= bus.cpu_addr;
                we_q    <= bus.cpu_we;
                wdata_q <= bus.cpu_wdata;
            end
            if (state_q == ST_CHECK) begin
                if (bus.cache_data_ready) begin
                    if (hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
                end else begin
                    if (miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
                end
            end
        end
    end

    // next-state, fill pointer and load-data capture
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE:      if (bus.cpu_req) state_d = bus.cpu_we ? ST_STORE_MEM : ST_LOOKUP;
            ST_LOOKUP:    state_d = ST_CHECK;
            ST_CHECK: begin
                if (bus.cache_data_ready) begin
                    rdata_d = bus.cache_data_out;
                    state_d = ST_DONE;
                end else begin
                    idx_d   = '0;
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                if (bus.mem_ack) begin
                    idx_d = idx_q + 1'b1;
                    if (idx_q == BLOCK_OFFSET'(NUM_OF_BLOCKS-1)) state_d = ST_REFILL;
                end
            end
            ST_REFILL: begin
                if (bus.cache_write_done) begin
                    rdata_d = buf_word;
                    state_d = ST_DONE;
                end
            end
            ST_STORE_MEM:   if (bus.mem_ack) state_d = ST_STORE_CACHE;
            ST_STORE_CACHE: if (bus.cache_write_done) state_d = ST_DONE;
            ST_DONE:        state_d = ST_IDLE;
            default:        state_d = ST_IDLE;
        endcase
    end

    assign store_mask = WORD_MASK << (32'(word_sel) * WORDSIZE);
    assign store_data = BLOCKSIZE'(wdata_q) << (32'(word_sel) * WORDSIZE);

    // controls decode from state; addresses and data come from latched registers
    always_comb begin
        bus.cpu_busy            = (state_q != ST_IDLE);
        bus.cpu_done            = (state_q == ST_DONE);
        bus.cpu_rdata           = rdata_q;
        bus.cache_r_en          = (state_q == ST_LOOKUP);
        bus.cache_wr_en         = (state_q == ST_REFILL) || (state_q == ST_STORE_CACHE);
        bus.cache_check_exist   = (state_q == ST_STORE_CACHE);
        bus.cache_address_read  = addr_q;
        bus.cache_address_write = addr_q;
        bus.cache_data_in       = we_q ? store_data : fill_block;
        bus.cache_data_mask     = '0;
        if (state_q == ST_REFILL)      bus.cache_data_mask = '1;
        if (state_q == ST_STORE_CACHE) bus.cache_data_mask = store_mask;
        bus.mem_req             = (state_q == ST_FILL) || (state_q == ST_STORE_MEM);
        bus.mem_we              = (state_q == ST_STORE_MEM);
        bus.mem_addr            = we_q ? {addr_q[ADDRESSIZE-1:OFFSETSIZE], {OFFSETSIZE{1'b0}}}
                                       : {addr_q[ADDRESSIZE-1:TAG_LSB], idx_q, {OFFSETSIZE{1'b0}}};
        bus.mem_wdata           = wdata_q;
        bus.hit_cnt             = hit_cnt_q;
        bus.miss_cnt            = miss_cnt_q;
    end
endmodule

// File: tb/tb_l1_miss_handler.sv
module tb_l1_miss_handler;
    import cache_pkg::*;

    logic clk, reset, inject_ack;
    int   vectors = 0, miscompares = 0;

    l1_miss_handler_if bus();
    l1_miss_handler dut (.clk(clk), .reset(reset), .bus(bus));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // cache model: registered hit/word on r_en, one-cycle write ack
    logic [BLOCKSIZE-1:0] cmem [int];
    int                   cwr_cnt = 0, ren_cnt = 0;
    logic [BLOCKSIZE-1:0] last_mask, last_data;
    logic                 last_chk;

    initial begin : cache_model
        logic [BLOCKSIZE-1:0] line, msk, dat;
        int key;
        logic [31:0] ra, wa;
        logic ren, wen, wdone, chk;
        line = '0;
        line[3*32 +: 32] = 32'hDEADBEEF;
        cmem[5] = line;
        bus.cache_data_ready = 1'b0;
        bus.cache_write_done = 1'b0;
        bus.cache_data_out   = '0;
        last_mask = '0; last_data = '0; last_chk = 1'b0;
        forever begin
            @(posedge clk);
            ren = bus.cache_r_en; ra = bus.cache_address_read;
            wen = bus.cache_wr_en; wa = bus.cache_address_write; wdone = bus.cache_write_done;
            chk = bus.cache_check_exist; msk = bus.cache_data_mask; dat = bus.cache_data_in;
            bus.cache_data_ready <= 1'b0;
            bus.cache_write_done <= 1'b0;
            if (ren) begin
                ren_cnt++;
                key = int'(ra >> 6);
                if (cmem.exists(key)) begin
                    line = cmem[key];
                    bus.cache_data_ready <= 1'b1;
                    bus.cache_data_out   <= line[int'(ra[5:2])*32 +: 32];
                end
            end
            if (wen && !wdone) begin
                bus.cache_write_done <= 1'b1;
                cwr_cnt++;
                last_mask = msk; last_data = dat; last_chk = chk;
                key = int'(wa >> 6);
                if (!chk || cmem.exists(key)) begin
                    line = cmem.exists(key) ? cmem[key] : '0;
                    cmem[key] = (line & ~msk) | (dat & msk);
                end
            end
        end
    end

    // memory model: 2-cycle ack latency, word i of a block reads 0x1000_0000+i
    logic [31:0] rlog[$], waddr_log[$], wdata_log[$];
    int          req_cyc = 0;

    initial begin : mem_model
        int lat;
        logic req, we, ack;
        logic [31:0] a, d;
        lat = 0;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(posedge clk);
            req = bus.mem_req; we = bus.mem_we; ack = bus.mem_ack;
            a = bus.mem_addr; d = bus.mem_wdata;
            if (req) req_cyc++;
            bus.mem_ack <= 1'b0;
            if (inject_ack) begin
                bus.mem_ack   <= 1'b1;
                bus.mem_rdata <= 32'hBAD0_0000;
                lat = 0;
            end else if (req && !ack) begin
                if (lat == 1) begin
                    bus.mem_ack   <= 1'b1;
                    bus.mem_rdata <= 32'h1000_0000 + {28'd0, a[5:2]};
                    if (we) begin
                        waddr_log.push_back(a);
                        wdata_log.push_back(d);
                    end else begin
                        rlog.push_back(a);
                    end
                    lat = 0;
                end else begin
                    lat++;
                end
            end else begin
                lat = 0;
            end
        end
    end

    // one CPU request; returns cycles from request cycle to cpu_done
    task automatic do_op(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input bit hold, output int cyc, output logic [31:0] rd);
        @(negedge clk);
        bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wd;
        cyc = 0; rd = '0;
        while (cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (!hold) begin
                bus.cpu_req = 1'b0; bus.cpu_addr = 32'hFFFF_FFFF; bus.cpu_wdata = 32'h5555_5555;
            end
            if (bus.cpu_done) begin
                rd = bus.cpu_rdata;
                break;
            end
        end
        bus.cpu_req = 1'b0;
        if (cyc >= 300) begin
            miscompares++;
            $display("FAIL op_timeout addr=%h got no cpu_done within 300 cycles", addr);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        vectors++; if ({bus.cpu_busy, bus.cpu_done, bus.cache_r_en, bus.cache_wr_en, bus.cache_check_exist, bus.mem_req, bus.mem_we} !== 7'd0) begin
            miscompares++; $display("FAIL reset_ctrl got=%b exp=0", {bus.cpu_busy, bus.cpu_done, bus.cache_r_en, bus.cache_wr_en, bus.cache_check_exist, bus.mem_req, bus.mem_we}); end
        vectors++; if ({bus.cpu_rdata, bus.mem_addr, bus.mem_wdata, bus.hit_cnt, bus.miss_cnt} !== '0) begin
            miscompares++; $display("FAIL reset_regs rdata=%h maddr=%h hit=%h miss=%h exp=0", bus.cpu_rdata, bus.mem_addr, bus.hit_cnt, bus.miss_cnt); end
        vectors++; if ({bus.cache_data_in, bus.cache_data_mask} !== '0) begin
            miscompares++; $display("FAIL reset_cache_bus got nonzero data/mask exp=0"); end
        reset = 1'b1;
    endtask

    task automatic test_load_hit();
        int cyc, rq0; logic [31:0] rd;
        rq0 = req_cyc;
        do_op(1'b0, 32'h0000_014C, '0, 1'b0, cyc, rd);
        vectors++; if (cyc !== 3) begin miscompares++; $display("FAIL hit_latency got=%0d exp=3", cyc); end
        vectors++; if (rd !== 32'hDEADBEEF) begin miscompares++; $display("FAIL hit_rdata got=%h exp=deadbeef", rd); end
        vectors++; if (bus.hit_cnt !== 16'd1) begin miscompares++; $display("FAIL hit_cnt got=%0d exp=1", bus.hit_cnt); end
        vectors++; if (req_cyc !== rq0) begin miscompares++; $display("FAIL hit_no_mem got=%0d exp=%0d", req_cyc, rq0); end
    endtask

    task automatic test_load_miss();
        int cyc, n0, cw0; logic [31:0] rd;
        n0 = rlog.size(); cw0 = cwr_cnt;
        do_op(1'b0, 32'h0000_2088, '0, 1'b0, cyc, rd);
        vectors++; if (rlog.size() !== n0 + 16) begin miscompares++; $display("FAIL miss_nreads got=%0d exp=16", rlog.size() - n0); end
        for (int i = 0; i < 16 && n0 + i < rlog.size(); i++) begin
            vectors++; if (rlog[n0+i] !== 32'h2080 + 32'(4*i)) begin
                miscompares++; $display("FAIL miss_raddr%0d got=%h exp=%h", i, rlog[n0+i], 32'h2080 + 32'(4*i)); end
        end
        vectors++; if (cyc !== 53) begin miscompares++; $display("FAIL miss_latency got=%0d exp=53", cyc); end
        vectors++; if (cwr_cnt !== cw0 + 1) begin miscompares++; $display("FAIL miss_nrefill got=%0d exp=1", cwr_cnt - cw0); end
        vectors++; if (last_mask !== {BLOCKSIZE{1'b1}} || last_chk !== 1'b0) begin
            miscompares++; $display("FAIL refill_mask chk=%b mask_lo=%h exp all ones chk=0", last_chk, last_mask[31:0]); end
        vectors++; if (last_data[15*32 +: 32] !== 32'h1000_000F) begin
            miscompares++; $display("FAIL refill_data w15 got=%h exp=1000000f", last_data[15*32 +: 32]); end
        vectors++; if (rd !== 32'h1000_0002) begin miscompares++; $display("FAIL miss_rdata got=%h exp=10000002", rd); end
        vectors++; if (bus.miss_cnt !== 16'd1) begin miscompares++; $display("FAIL miss_cnt got=%0d exp=1", bus.miss_cnt); end
        do_op(1'b0, 32'h0000_2088, '0, 1'b0, cyc, rd);
        vectors++; if (cyc !== 3 || rd !== 32'h1000_0002) begin
            miscompares++; $display("FAIL miss_rehit cyc=%0d rd=%h exp 3/10000002", cyc, rd); end
        vectors++; if (bus.hit_cnt !== 16'd2) begin miscompares++; $display("FAIL rehit_cnt got=%0d exp=2", bus.hit_cnt); end
    endtask

    task automatic test_store_hit();
        int cyc; logic [31:0] rd; logic [BLOCKSIZE-1:0] exp_mask;
        exp_mask = '0; exp_mask[191:160] = '1;
        do_op(1'b1, 32'h0000_2097, 32'hCAFEF00D, 1'b0, cyc, rd);
        vectors++; if (cyc !== 6) begin miscompares++; $display("FAIL store_latency got=%0d exp=6", cyc); end
        vectors++; if (waddr_log.size() !== 1 || waddr_log[0] !== 32'h2094 || wdata_log[0] !== 32'hCAFEF00D) begin
            miscompares++; $display("FAIL store_mem n=%0d exp one write cafef00d@2094", waddr_log.size()); end
        vectors++; if (last_chk !== 1'b1 || last_mask !== exp_mask) begin
            miscompares++; $display("FAIL store_mask chk=%b mask_w5=%h exp chk=1 only [191:160]", last_chk, last_mask[191:160]); end
        vectors++; if (last_data[191:160] !== 32'hCAFEF00D) begin
            miscompares++; $display("FAIL store_data got=%h exp=cafef00d", last_data[191:160]); end
        do_op(1'b0, 32'h0000_2094, '0, 1'b0, cyc, rd);
        vectors++; if (rd !== 32'hCAFEF00D || bus.hit_cnt !== 16'd3) begin
            miscompares++; $display("FAIL store_readback rd=%h hit=%0d exp cafef00d/3", rd, bus.hit_cnt); end
    endtask

    task automatic test_store_miss();
        int cyc; logic [31:0] rd;
        do_op(1'b1, 32'h0000_3000, 32'h1234_5678, 1'b0, cyc, rd);
        vectors++; if (waddr_log.size() !== 2 || waddr_log[1] !== 32'h3000 || wdata_log[1] !== 32'h1234_5678) begin
            miscompares++; $display("FAIL smiss_mem n=%0d exp write 12345678@3000", waddr_log.size()); end
        vectors++; if (cmem.exists(32'h3000 >> 6) !== 1'b0) begin
            miscompares++; $display("FAIL smiss_alloc got line present exp absent"); end
        do_op(1'b0, 32'h0000_3000, '0, 1'b0, cyc, rd);
        vectors++; if (bus.miss_cnt !== 16'd2 || rd !== 32'h1000_0000) begin
            miscompares++; $display("FAIL smiss_reload miss=%0d rd=%h exp 2/10000000", bus.miss_cnt, rd); end
    endtask

    task automatic test_busy_hold();
        int cyc, re0, n0; logic [31:0] rd;
        re0 = ren_cnt; n0 = rlog.size();
        do_op(1'b0, 32'h0000_4004, '0, 1'b1, cyc, rd);
        @(negedge clk);
        vectors++; if (ren_cnt !== re0 + 1 || rlog.size() !== n0 + 16) begin
            miscompares++; $display("FAIL busy_reaccept lookups=%0d reads=%0d exp 1/16", ren_cnt - re0, rlog.size() - n0); end
        vectors++; if (cyc !== 53 || rd !== 32'h1000_0001 || bus.cpu_busy !== 1'b0) begin
            miscompares++; $display("FAIL busy_result cyc=%0d rd=%h busy=%b exp 53/10000001/0", cyc, rd, bus.cpu_busy); end
    endtask

    task automatic test_reset_mid_fill();
        int n0, cw0, k;
        n0 = rlog.size(); cw0 = cwr_cnt;
        @(negedge clk);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h0000_5000;
        @(negedge clk);
        bus.cpu_req = 1'b0;
        k = 0;
        while (rlog.size() < n0 + 8 && k < 200) begin @(negedge clk); k++; end
        vectors++; if (k >= 200) begin miscompares++; $display("FAIL midfill_timeout reads=%0d exp 8", rlog.size() - n0); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        vectors++; if ({bus.cpu_busy, bus.cpu_done, bus.cache_wr_en, bus.mem_req, bus.mem_we} !== 5'd0 || bus.miss_cnt !== 16'd0) begin
            miscompares++; $display("FAIL midfill_reset busy=%b req=%b miss=%0d exp 0", bus.cpu_busy, bus.mem_req, bus.miss_cnt); end
        vectors++; if ({bus.cache_data_in, bus.cache_data_mask, bus.mem_addr, bus.cpu_rdata} !== '0) begin
            miscompares++; $display("FAIL midfill_buses maddr=%h data_lo=%h exp 0", bus.mem_addr, bus.cache_data_in[31:0]); end
        reset = 1'b1;
        @(negedge clk);
        inject_ack = 1'b1;
        @(negedge clk);
        inject_ack = 1'b0;
        repeat (3) @(negedge clk);
        vectors++; if (bus.cpu_busy !== 1'b0 || bus.mem_req !== 1'b0 || cwr_cnt !== cw0) begin
            miscompares++; $display("FAIL late_ack busy=%b req=%b cache_writes=%0d exp 0/0/0", bus.cpu_busy, bus.mem_req, cwr_cnt - cw0); end
    endtask

    task automatic test_saturation();
        int cyc; logic [31:0] rd;
        @(negedge clk);
        force dut.hit_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.hit_cnt_q;
        do_op(1'b0, 32'h0000_014C, '0, 1'b0, cyc, rd);
        vectors++; if (bus.hit_cnt !== 16'hFFFF || rd !== 32'hDEADBEEF) begin
            miscompares++; $display("FAIL hit_saturate got=%h rd=%h exp ffff/deadbeef", bus.hit_cnt, rd); end
        vectors++; if (bus.miss_cnt !== 16'd0) begin miscompares++; $display("FAIL sat_miss got=%0d exp=0", bus.miss_cnt); end
    endtask

    initial begin
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        reset = 1'b0; inject_ack = 1'b0;
        test_reset();
        test_load_hit();
        test_load_miss();
        test_store_hit();
        test_store_miss();
        test_busy_hold();
        test_reset_mid_fill();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
